int_seq: RTL

Interrupt sequencer that sits directly downstream of the per-source interrupt blocks and consumes their REQI lines. It arbitrates among pending requests by fixed priority and drives a single interrupt line to the CPU. It supplies a vector on CPU acknowledge, tracks in-service sources, and returns a one-cycle RTI pulse to the serviced source's interrupt block when the CPU executes its return.

---
 rtl/int_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/int_seq.sv
// int_seq: fixed-priority interrupt sequencer; REQI->INT, INTA->VEC and IRET->RTI each take 1 cycle, plus one DONE cycle per retire.
// Requests are level and held until RTI; define INT_SEQ_NEST_EN to allow pre-emption of an in-service source.
module int_seq #(
    parameter int               N_SRC    = 4,
    parameter int               VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = 'h20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] REQI,
    input  logic             CPU_IE,
    input  logic             INTA,
    input  logic             IRET,
    output logic             INT,
    output logic [VEC_W-1:0] VEC,
    output logic             VEC_VALID,
    output logic [N_SRC-1:0] RTI,
    output logic [N_SRC-1:0] ISR_ACTIVE
);

    localparam int WIN_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, PEND, SERVICE, DONE} state_t;

    state_t             state;
    logic [WIN_W-1:0]   win;
    logic [WIN_W-1:0]   win_nxt;
    logic               from_svc;
    logic [N_SRC-1:0]   isr_low;
    logic [N_SRC-1:0]   elig;

    // One-hot of the lowest set in-service bit (the innermost, highest-priority handler).
    assign isr_low = ISR_ACTIVE & (~ISR_ACTIVE + N_SRC'(1));

`ifdef INT_SEQ_NEST_EN
    // Only sources above the innermost in-service one may pre-empt; all ones when nothing is in service.
    assign elig = REQI & (isr_low - N_SRC'(1));
`else
    assign elig = REQI & ~ISR_ACTIVE;
`endif

    always_comb begin
        win_nxt = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win_nxt = WIN_W'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            win        <= '0;
            from_svc   <= 1'b0;
            INT        <= 1'b0;
            VEC        <= '0;
            VEC_VALID  <= 1'b0;
            RTI        <= '0;
            ISR_ACTIVE <= '0;
        end else begin
            VEC_VALID <= 1'b0;
            RTI       <= '0;
            case (state)
                IDLE: begin
                    if (CPU_IE && |elig) begin
                        win      <= win_nxt;
                        from_svc <= 1'b0;
                        INT      <= 1'b1;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    // Acknowledge takes precedence over a coincident withdrawal.
                    if (INTA) begin
                        VEC             <= VEC_BASE + VEC_W'(win);
                        VEC_VALID       <= 1'b1;
                        ISR_ACTIVE[win] <= 1'b1;
                        INT             <= 1'b0;
                        state           <= SERVICE;
                    end else if (!REQI[win]) begin
                        INT   <= 1'b0;
                        state <= from_svc ? SERVICE : IDLE;
                    end
                end
                SERVICE: begin
                    if (IRET) begin
                        RTI        <= isr_low;
                        ISR_ACTIVE <= ISR_ACTIVE & ~isr_low;
                        state      <= DONE;
                    end
`ifdef INT_SEQ_NEST_EN
                    else if (CPU_IE && |elig) begin
                        win      <= win_nxt;
                        from_svc <= 1'b1;
                        INT      <= 1'b1;
                        state    <= PEND;
                    end
`endif
                end
                DONE: begin
                    // Recovery cycle lets the retired source drop REQI before arbitration resumes.
                    state <= (|ISR_ACTIVE) ? SERVICE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
